cv32e40x_saes32_ctrl: RTL and testbench
=======================================

Name: cv32e40x_saes32_ctrl

Overview:
Sequencer for the first-order DOM-protected AES round-function datapath (saes32 enc/dec, sbox and mix variants).
- Accepts one instruction at a time from the execute stage.
- Fetches fresh mask/randomness from the RNG, then drives the datapath with stable registered operands for the full sbox pipeline latency.
- Captures the result and returns it under a valid/ready handshake.
- Replaces the current combinational "ready = valid" hand-off, so the pipelined sbox can be used safely.

Parameters:
SBOX_LATENCY, 4, cycles from operands/shares stable at datapath input to valid dp_rd_i (0 = combinational).
RNG_W, 44, RNG word width; bits [7:0] = share B byte, bits [43:8] = 36 sbox random bits.

Ports:
clk  in  1  core clock
reset_n  in  1  asynchronous active-low reset
in_valid_i  in  1  instruction request
in_ready_o  out  1  controller can accept
in_rs1_i  in  32  round key / accumulator operand
in_rs2_i  in  32  state column operand
in_bs_i  in  2  byte select
in_op_i  in  4  one-hot {encsm, encs, decsm, decs}
kill_i  in  1  pipeline flush
rng_req_o  out  1  randomness request
rng_valid_i  in  1  randomness available
rng_data_i  in  RNG_W  random word
dp_rs1_o  out  32  registered rs1 to datapath
dp_rs2_o  out  32  registered rs2 to datapath
dp_bs_o  out  2  registered byte select
dp_op_o  out  4  registered one-hot op
dp_shareB_o  out  8  registered share B byte
dp_randombits_o  out  36  registered sbox randomness
dp_valid_o  out  1  datapath inputs valid (EXEC)
dp_rd_i  in  32  datapath result
result_valid_o  out  1  result available
result_ready_i  in  1  consumer takes result
result_o  out  32  registered result
result_err_o  out  1  illegal op encoding
busy_o  out  1  state != IDLE

Behaviour:
Reset:
- state=IDLE.
- All outputs 0.
- All operand, share and result registers 0.

States and transitions:
- IDLE:
  - in_ready_o=1.
  - On in_valid_i && !kill_i: latch rs1, rs2, bs, op.
  - If in_op_i is one-hot, go to RNG.
  - Otherwise (zero bits or >1 bit set): result_o=0, result_err_o=1, go to DONE. No RNG handshake occurs.
- RNG:
  - rng_req_o=1.
  - On rng_valid_i: latch [7:0] into shareB and [43:8] into randombits.
  - Load counter = SBOX_LATENCY, go to EXEC.
  - Waits indefinitely for rng_valid_i.
- EXEC:
  - dp_valid_o=1.
  - All dp_* outputs are held constant; no bit may toggle during EXEC (mask integrity).
  - Counter decrements each cycle.
  - In the cycle counter==0: capture dp_rd_i into result_o, result_err_o=0, go to DONE.
  - Latency rng handshake to result_valid_o = SBOX_LATENCY+1 cycles.
- DONE:
  - result_valid_o=1; result_o and result_err_o stable.
  - On result_ready_i: go to IDLE. in_ready_o rises the next cycle; there is no accept in the same cycle.

General rules:
- Exactly one RNG handshake per legal op; randomness is never reused across ops.
- rng_valid_i outside RNG is ignored.
- kill_i in any state: next state is IDLE.
  - rng_req_o, dp_valid_o and result_valid_o are 0 from the next cycle.
  - kill has priority over a simultaneous accept, RNG handshake, capture or result_ready_i.
  - A pending RNG word is not consumed.
- The counter is never loaded outside the RNG->EXEC transition.
- It saturates at 0 and has width $clog2(SBOX_LATENCY+1), minimum 1.
- Reset asserted mid-operation: immediate return to the reset values; no result is produced.

Optional Feature:
CV32E40X_SAES_ZEROIZE_EN
- Defined: on the DONE->IDLE handoff or on kill_i, the operand, shareB, randombits and result registers clear to 0 on the next edge. dp_* outputs and result_o read 0 in IDLE.
- Undefined: registers retain stale values until the next capture. Outputs other than the valid/ready/busy signals are don't-care in IDLE.

Decomposition:
Package cv32e40x_saes_pkg holds:
- state enum saes_state_e {IDLE, RNG, EXEC, DONE}
- op one-hot bit index localparams (OP_DECS=0, OP_DECSM=1, OP_ENCS=2, OP_ENCSM=3)
- RNG field localparams (SHAREB_LSB=0, SHAREB_W=8, RAND_LSB=8, RAND_W=36)

No sub-module; the counter and FSM are inline. The bench instantiates this block together with riscv_crypto_fu_saes32_protected.

Test Plan:
1. encs, rs1=0, rs2=0x00000000, bs=0, rng_valid_i 2 cycles after rng_req_o, rng_data_i=0x5A_A5C3_F00F_1 -> result_o=0x00000063 exactly SBOX_LATENCY+1 cycles after the RNG handshake; dp_* stable throughout EXEC.
2. encsm, rs1=0x01020304, rs2=0, bs=0 -> result_o=0xA5 63 63 C6 ^ 0x01020304 = 0xA46160C2. Then decs, rs2=0x00006300, bs=1 -> 0x00000000.
3. Result backpressure: hold result_ready_i=0 for 10 cycles -> result_valid_o and result_o stable, in_ready_o=0, no second rng_req_o. Release -> in_ready_o=1 the following cycle.
4. kill_i asserted in RNG, in EXEC (counter=2), and in DONE coincident with result_ready_i -> IDLE next cycle, no result_valid_o pulse. A later op completes normally with fresh RNG.
5. in_op_i=4'b0000 and 4'b0101 -> result_err_o=1, result_o=0, rng_req_o never asserted. A following legal op gives result_err_o=0.
6. Reset asserted mid-EXEC -> all outputs 0 asynchronously. Repeat scenario 1 with SBOX_LATENCY=0, and (zeroize build) dp_rs2_o=0 after handoff.

Source files
------------

// File: rtl/cv32e40x_saes_pkg.sv
// Shared types and field positions for the saes32 sequencer and its datapath.
package cv32e40x_saes_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RNG  = 2'd1,
    EXEC = 2'd2,
    DONE = 2'd3
  } saes_state_e;

  localparam int unsigned OP_DECS  = 0;
  localparam int unsigned OP_DECSM = 1;
  localparam int unsigned OP_ENCS  = 2;
  localparam int unsigned OP_ENCSM = 3;

  localparam int unsigned SHAREB_LSB = 0;
  localparam int unsigned SHAREB_W   = 8;
  localparam int unsigned RAND_LSB   = 8;
  localparam int unsigned RAND_W     = 36;

  // Exactly one bit set; zero and multi-bit encodings are illegal ops.
  function automatic logic op_is_onehot(input logic [3:0] op);
    return (op != 4'b0000) && ((op & (op - 4'd1)) == 4'b0000);
  endfunction

endpackage

// File: rtl/cv32e40x_saes32_ctrl_if.sv
// Handshake bundle between execute stage, RNG, protected datapath and the saes32 sequencer.
interface cv32e40x_saes32_ctrl_if #(
  parameter int unsigned RNG_W = 44
);
  logic             in_valid_i;
  logic             in_ready_o;
  logic [31:0]      in_rs1_i;
  logic [31:0]      in_rs2_i;
  logic [1:0]       in_bs_i;
  logic [3:0]       in_op_i;
  logic             kill_i;
  logic             rng_req_o;
  logic             rng_valid_i;
  logic [RNG_W-1:0] rng_data_i;
  logic [31:0]      dp_rs1_o;
  logic [31:0]      dp_rs2_o;
  logic [1:0]       dp_bs_o;
  logic [3:0]       dp_op_o;
  logic [7:0]       dp_shareB_o;
  logic [35:0]      dp_randombits_o;
  logic             dp_valid_o;
  logic [31:0]      dp_rd_i;
  logic             result_valid_o;
  logic             result_ready_i;
  logic [31:0]      result_o;
  logic             result_err_o;
  logic             busy_o;

  modport slave (
    input  in_valid_i, in_rs1_i, in_rs2_i, in_bs_i, in_op_i, kill_i,
           rng_valid_i, rng_data_i, dp_rd_i, result_ready_i,
    output in_ready_o, rng_req_o, dp_rs1_o, dp_rs2_o, dp_bs_o, dp_op_o,
           dp_shareB_o, dp_randombits_o, dp_valid_o, result_valid_o,
           result_o, result_err_o, busy_o
  );

  modport master (
    output in_valid_i, in_rs1_i, in_rs2_i, in_bs_i, in_op_i, kill_i,
           rng_valid_i, rng_data_i, dp_rd_i, result_ready_i,
    input  in_ready_o, rng_req_o, dp_rs1_o, dp_rs2_o, dp_bs_o, dp_op_o,
           dp_shareB_o, dp_randombits_o, dp_valid_o, result_valid_o,
           result_o, result_err_o, busy_o
  );
endinterface

// File: rtl/cv32e40x_saes32_ctrl.sv
// Sequencer for the DOM-masked saes32 datapath: accept op, fetch fresh RNG, hold operands for the sbox latency, return result.
// Optional CV32E40X_SAES_ZEROIZE_EN clears operand, share and result registers on handoff and on kill.
module cv32e40x_saes32_ctrl
  import cv32e40x_saes_pkg::*;
#(
  parameter int unsigned SBOX_LATENCY = 4,
  parameter int unsigned RNG_W        = 44
) (
  input logic                   clk,
  input logic                   reset_n,
  cv32e40x_saes32_ctrl_if.slave bus
);

  localparam int unsigned      CNT_W    = (SBOX_LATENCY > 0) ? $clog2(SBOX_LATENCY + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SBOX_LATENCY);

  saes_state_e         state_q, state_d;
  logic                ready_q, ready_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [31:0]         rs1_q, rs1_d;
  logic [31:0]         rs2_q, rs2_d;
  logic [1:0]          bs_q, bs_d;
  logic [3:0]          op_q, op_d;
  logic [SHAREB_W-1:0] shareb_q, shareb_d;
  logic [RAND_W-1:0]   rand_q, rand_d;
  logic [31:0]         result_q, result_d;
  logic                err_q, err_d;

  always_comb begin
    // NOTE: every next-state signal takes its held value first, so no path leaves one unassigned and no latch is inferred.
    state_d  = state_q;
    cnt_d    = cnt_q;
    rs1_d    = rs1_q;
    rs2_d    = rs2_q;
    bs_d     = bs_q;
    op_d     = op_q;
    shareb_d = shareb_q;
    rand_d   = rand_q;
    result_d = result_q;
    err_d    = err_q;

    // Kill wins over accept, RNG handshake, capture and handoff; a pending RNG word stays unconsumed.
    if (bus.kill_i) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (ready_q && bus.in_valid_i) begin
            rs1_d = bus.in_rs1_i;
            rs2_d = bus.in_rs2_i;
            bs_d  = bus.in_bs_i;
            op_d  = bus.in_op_i;
            if (op_is_onehot(bus.in_op_i)) begin
              state_d = RNG;
            end else begin
              result_d = '0;
              err_d    = 1'b1;
              state_d  = DONE;
            end
          end
        end
        RNG: begin
          if (bus.rng_valid_i) begin
            shareb_d = bus.rng_data_i[SHAREB_LSB +: SHAREB_W];
            rand_d   = bus.rng_data_i[RAND_LSB +: RAND_W];
            cnt_d    = CNT_LOAD;
            state_d  = EXEC;
          end
        end
        EXEC: begin
          if (cnt_q == '0) begin
            result_d = bus.dp_rd_i;
            err_d    = 1'b0;
            state_d  = DONE;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        DONE: begin
          if (bus.result_ready_i) state_d = IDLE;
        end
      endcase
    end

`ifdef CV32E40X_SAES_ZEROIZE_EN
    if (bus.kill_i || (state_q == DONE && bus.result_ready_i)) begin
      rs1_d    = '0;
      rs2_d    = '0;
      bs_d     = '0;
      op_d     = '0;
      shareb_d = '0;
      rand_d   = '0;
      result_d = '0;
      err_d    = 1'b0;
    end
`endif

    // Ready is registered so it reads 0 while in reset and rises one cycle after any return to IDLE.
    ready_d = (state_d == IDLE);
  end

  // NOTE: operand, share and result registers are reset too, because every output must read 0 under reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      ready_q  <= 1'b0;
      cnt_q    <= '0;
      rs1_q    <= '0;
      rs2_q    <= '0;
      bs_q     <= '0;
      op_q     <= '0;
      shareb_q <= '0;
      rand_q   <= '0;
      result_q <= '0;
      err_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so all registers update from the same pre-edge values.
      state_q  <= state_d;
      ready_q  <= ready_d;
      cnt_q    <= cnt_d;
      rs1_q    <= rs1_d;
      rs2_q    <= rs2_d;
      bs_q     <= bs_d;
      op_q     <= op_d;
      shareb_q <= shareb_d;
      rand_q   <= rand_d;
      result_q <= result_d;
      err_q    <= err_d;
    end
  end

  assign bus.in_ready_o      = ready_q;
  assign bus.rng_req_o       = (state_q == RNG);
  assign bus.dp_valid_o      = (state_q == EXEC);
  assign bus.result_valid_o  = (state_q == DONE);
  assign bus.busy_o          = (state_q != IDLE);
  assign bus.dp_rs1_o        = rs1_q;
  assign bus.dp_rs2_o        = rs2_q;
  assign bus.dp_bs_o         = bs_q;
  assign bus.dp_op_o         = op_q;
  assign bus.dp_shareB_o     = shareb_q;
  assign bus.dp_randombits_o = rand_q;
  assign bus.result_o        = result_q;
  assign bus.result_err_o    = err_q;

endmodule

// File: tb/tb_cv32e40x_saes32_ctrl.sv
// Directed bench for cv32e40x_saes32_ctrl with a behavioural saes32 datapath (pipelined and combinational instances).
module tb_cv32e40x_saes32_ctrl;
  import cv32e40x_saes_pkg::*;

  localparam int L = 4;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  cv32e40x_saes32_ctrl_if #(.RNG_W(44)) bus ();
  cv32e40x_saes32_ctrl_if #(.RNG_W(44)) bus0 ();

  cv32e40x_saes32_ctrl #(.SBOX_LATENCY(L), .RNG_W(44)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus)
  );
  cv32e40x_saes32_ctrl #(.SBOX_LATENCY(0), .RNG_W(44)) dut0 (
    .clk(clk), .reset_n(reset_n), .bus(bus0)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [159:0] got, input logic [159:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Small saes32 reference: only the sbox entries the vectors use.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    case (x)
      8'h00:   return 8'h63;
      8'h01:   return 8'h7C;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] x);
    case (x)
      8'h63:   return 8'h00;
      8'h00:   return 8'h52;
      8'h7C:   return 8'h01;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
  endfunction

  function automatic logic [31:0] dp_f(input logic [31:0] rs1, input logic [31:0] rs2,
                                       input logic [1:0] bs, input logic [3:0] op);
    logic [7:0]  x, y, m2, m4, m8;
    logic [31:0] col;
    x = rs2[8*bs +: 8];
    y = (op[OP_ENCS] || op[OP_ENCSM]) ? sbox(x) : inv_sbox(x);
    m2 = xt(y);
    m4 = xt(m2);
    m8 = xt(m4);
    if (op[OP_ENCSM])      col = {m2 ^ y, y, y, m2};
    else if (op[OP_DECSM]) col = {m8 ^ m2 ^ y, m8 ^ m4 ^ y, m8 ^ y, m8 ^ m4 ^ m2};
    else                   col = {24'h0, y};
    case (bs)
      2'd0:    return col ^ rs1;
      2'd1:    return {col[23:0], col[31:24]} ^ rs1;
      2'd2:    return {col[15:0], col[31:16]} ^ rs1;
      default: return {col[7:0], col[31:8]} ^ rs1;
    endcase
  endfunction

  // Pipelined datapath: poisoned unless operands were valid for the full latency.
  logic [31:0] pipe [L];
  always @(posedge clk) begin
    pipe[0] <= bus.dp_valid_o ? dp_f(bus.dp_rs1_o, bus.dp_rs2_o, bus.dp_bs_o, bus.dp_op_o) : 32'hDEADBEEF;
    for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
  end
  assign bus.dp_rd_i  = pipe[L-1];
  assign bus0.dp_rd_i = bus0.dp_valid_o ? dp_f(bus0.dp_rs1_o, bus0.dp_rs2_o, bus0.dp_bs_o, bus0.dp_op_o)
                                        : 32'hDEADBEEF;

  function automatic logic [113:0] dp_vec();
    return {bus.dp_rs1_o, bus.dp_rs2_o, bus.dp_bs_o, bus.dp_op_o, bus.dp_shareB_o, bus.dp_randombits_o};
  endfunction

  function automatic logic [151:0] outs_main();
    return {bus.in_ready_o, bus.rng_req_o, dp_vec(), bus.dp_valid_o, bus.result_valid_o,
            bus.result_o, bus.result_err_o, bus.busy_o};
  endfunction

  logic [43:0] last_rnd = '0;

  task automatic start_op(input logic [3:0] op, input logic [31:0] rs1, input logic [31:0] rs2,
                          input logic [1:0] bs);
    bus.in_valid_i = 1'b1;
    bus.in_op_i    = op;
    bus.in_rs1_i   = rs1;
    bus.in_rs2_i   = rs2;
    bus.in_bs_i    = bs;
    @(negedge clk);
    bus.in_valid_i = 1'b0;
  endtask

  // Returns on the negedge right after the handshake edge.
  task automatic give_rng(input string tag, input logic [43:0] rnd, input int delay);
    int n = 0;
    while (!bus.rng_req_o && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({tag, ":req"}, bus.rng_req_o, 1'b1);
    repeat (delay) @(negedge clk);
    bus.rng_data_i  = rnd;
    bus.rng_valid_i = 1'b1;
    @(negedge clk);
    bus.rng_valid_i = 1'b0;
    check({tag, ":req_drop"}, bus.rng_req_o, 1'b0);
    last_rnd = rnd;
  endtask

  task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] rs1,
                        input logic [31:0] rs2, input logic [1:0] bs, input logic [43:0] rnd,
                        input logic [31:0] exp_res, input logic exp_err, input int hold);
    logic [113:0] snap;
    logic         stable, bp_ok;
    int           j;
    check({tag, ":ready"}, bus.in_ready_o, 1'b1);
    start_op(op, rs1, rs2, bs);
    if (!exp_err) begin
      give_rng(tag, rnd, 1);
      snap   = dp_vec();
      stable = 1'b1;
      j      = 0;
      while (!bus.result_valid_o && j < 50) begin
        if (dp_vec() !== snap || !bus.dp_valid_o) stable = 1'b0;
        @(negedge clk);
        j++;
      end
      check({tag, ":latency"}, j, L + 1);
      check({tag, ":dp_stable"}, stable, 1'b1);
      check({tag, ":shareB"}, bus.dp_shareB_o, rnd[7:0]);
      check({tag, ":rand"}, bus.dp_randombits_o, rnd[43:8]);
      check({tag, ":dp_rs1"}, bus.dp_rs1_o, rs1);
      check({tag, ":dp_op"}, bus.dp_op_o, op);
    end else begin
      check({tag, ":no_req"}, bus.rng_req_o, 1'b0);
    end
    check({tag, ":valid"}, bus.result_valid_o, 1'b1);
    check({tag, ":result"}, bus.result_o, exp_res);
    check({tag, ":err"}, bus.result_err_o, exp_err);
    if (hold > 0) begin
      bp_ok = 1'b1;
      repeat (hold) begin
        @(negedge clk);
        if (!bus.result_valid_o || bus.result_o !== exp_res || bus.in_ready_o ||
            bus.rng_req_o || !bus.busy_o) bp_ok = 1'b0;
      end
      check({tag, ":backpressure"}, bp_ok, 1'b1);
    end
    bus.result_ready_i = 1'b1;
    @(negedge clk);
    bus.result_ready_i = 1'b0;
    check({tag, ":handoff"}, {bus.result_valid_o, bus.in_ready_o, bus.busy_o}, 3'b010);
`ifdef CV32E40X_SAES_ZEROIZE_EN
    check({tag, ":zero_rs2"}, bus.dp_rs2_o, 32'h0);
    check({tag, ":zero_res"}, bus.result_o, 32'h0);
`endif
  endtask

  initial begin
    logic seen;
    int   n;
    bus.in_valid_i = 0; bus.in_rs1_i = 0; bus.in_rs2_i = 0; bus.in_bs_i = 0; bus.in_op_i = 0;
    bus.kill_i = 0; bus.rng_valid_i = 0; bus.rng_data_i = 0; bus.result_ready_i = 0;
    bus0.in_valid_i = 0; bus0.in_rs1_i = 0; bus0.in_rs2_i = 0; bus0.in_bs_i = 0; bus0.in_op_i = 0;
    bus0.kill_i = 0; bus0.rng_valid_i = 0; bus0.rng_data_i = 0; bus0.result_ready_i = 0;

    repeat (3) @(negedge clk);
    check("reset_outs", outs_main(), 152'h0);
    reset_n = 1'b1;
    @(negedge clk);
    check("post_reset", {bus.in_ready_o, bus.busy_o, bus.rng_req_o}, 3'b100);

    // 1/2/3: legal ops with hand-computed results
    run_op("t1_encs", 4'b0100, 32'h0, 32'h0, 2'd0, 44'h5AA5C3F00F1, 32'h00000063, 1'b0, 0);
    run_op("t2_encsm", 4'b1000, 32'h01020304, 32'h0, 2'd0, 44'h123456789AB, 32'hA46160C2, 1'b0, 0);
    run_op("t2_decs", 4'b0001, 32'h0, 32'h00006300, 2'd1, 44'hFEDCBA98765, 32'h00000000, 1'b0, 0);
    run_op("t3_bp", 4'b0100, 32'hFFFF0000, 32'h0, 2'd2, 44'h0F0F0F0F0F0, 32'hFF9C0000, 1'b0, 10);

    // 5: illegal encodings, then a legal op clears the error
    run_op("t5_zero", 4'b0000, 32'h1234, 32'h5678, 2'd0, 44'h0, 32'h0, 1'b1, 0);
    run_op("t5_multi", 4'b0101, 32'h1234, 32'h5678, 2'd0, 44'h0, 32'h0, 1'b1, 0);
    run_op("t5_legal", 4'b0100, 32'h11111111, 32'h01000000, 2'd3, 44'h2468ACE1357,
           32'h6D111111, 1'b0, 0);

    // 4a: kill in RNG with a simultaneous RNG word; the word must not be taken
    start_op(4'b0100, 32'h0, 32'h0, 2'd0);
    check("k_rng:req", bus.rng_req_o, 1'b1);
    bus.kill_i = 1'b1;
    bus.rng_valid_i = 1'b1;
    bus.rng_data_i = 44'hABCDEF01234;
    @(negedge clk);
    bus.kill_i = 1'b0;
    bus.rng_valid_i = 1'b0;
    check("k_rng:state", {bus.rng_req_o, bus.dp_valid_o, bus.busy_o, bus.in_ready_o}, 4'b0001);
`ifdef CV32E40X_SAES_ZEROIZE_EN
    check("k_rng:shareB", bus.dp_shareB_o, 8'h00);
`else
    check("k_rng:shareB", bus.dp_shareB_o, last_rnd[7:0]);
`endif

    // 4b: kill in EXEC with counter at 2
    start_op(4'b0100, 32'h0, 32'h0, 2'd0);
    give_rng("k_exec", 44'h13579BDF024, 0);
    repeat (2) @(negedge clk);
    check("k_exec:in_exec", bus.dp_valid_o, 1'b1);
    bus.kill_i = 1'b1;
    @(negedge clk);
    bus.kill_i = 1'b0;
    check("k_exec:state", {bus.dp_valid_o, bus.busy_o, bus.in_ready_o}, 3'b001);
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (bus.result_valid_o) seen = 1'b1;
    end
    check("k_exec:no_result", seen, 1'b0);

    // 4c: kill in DONE coincident with result_ready_i
    start_op(4'b0100, 32'h0, 32'h0, 2'd0);
    give_rng("k_done", 44'h0A0B0C0D0E0, 0);
    n = 0;
    while (!bus.result_valid_o && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("k_done:valid", bus.result_valid_o, 1'b1);
    bus.kill_i = 1'b1;
    bus.result_ready_i = 1'b1;
    @(negedge clk);
    bus.kill_i = 1'b0;
    bus.result_ready_i = 1'b0;
    check("k_done:state", {bus.result_valid_o, bus.busy_o, bus.in_ready_o}, 3'b001);

    run_op("t4_after", 4'b0001, 32'h0, 32'h0, 2'd0, 44'h7654321FEDC, 32'h00000052, 1'b0, 0);

    // 6: combinational datapath instance, latency 1 from the handshake
    bus0.in_valid_i = 1'b1;
    bus0.in_op_i = 4'b0100;
    @(negedge clk);
    bus0.in_valid_i = 1'b0;
    check("l0:req", bus0.rng_req_o, 1'b1);
    bus0.rng_valid_i = 1'b1;
    bus0.rng_data_i = 44'h5AA5C3F00F1;
    @(negedge clk);
    bus0.rng_valid_i = 1'b0;
    check("l0:exec", {bus0.dp_valid_o, bus0.result_valid_o, bus0.dp_shareB_o}, 10'b10_1111_0001);
    @(negedge clk);
    check("l0:valid", bus0.result_valid_o, 1'b1);
    check("l0:result", bus0.result_o, 32'h00000063);
    bus0.result_ready_i = 1'b1;
    @(negedge clk);
    bus0.result_ready_i = 1'b0;
    check("l0:handoff", {bus0.result_valid_o, bus0.in_ready_o}, 2'b01);

    // 6: asynchronous reset mid-EXEC
    start_op(4'b1000, 32'hCAFEF00D, 32'h0, 2'd0);
    give_rng("rst", 44'hFFFFFFFFFFF, 0);
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1 check("rst:outs", outs_main(), 152'h0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("rst:recover", {bus.in_ready_o, bus.result_valid_o, bus.busy_o}, 3'b100);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule
